// File: rtl/mips_inst_encoder.sv
// -----------------------------------------------------------------------------
// mips_inst_encoder
//
// Turns symbolic instruction descriptors into 32-bit MIPS words and writes
// them one after another into instruction memory. The boot/test loader uses it
// to fill IM before the CPU is let out of reset. It covers exactly the
// instruction set that the CPU decoder understands.
//
// Ports:
//   clk, rstn         clock (rising edge), asynchronous active-low reset
//   start             one-cycle pulse that begins or restarts a load session
//   in_valid/in_ready descriptor stream handshake
//   in_op             symbolic opcode (0..25 legal, 26..31 illegal)
//   in_rs/rt/rd/shamt register and shift-amount fields
//   in_imm            imm26 for J/JAL; bits [15:0] are imm16 for I-type
//   in_last           the descriptor is the final one of the session
//   im_we/im_addr/im_wdata  IM write port (byte address, one-cycle strobe)
//   busy, done        FSM is in LOAD / DONE
//   err               sticky: an illegal op was accepted this session
//   full              sticky: DEPTH words were written without in_last
//   count             number of words written this session
//
// Handshake: a descriptor transfers on a rising edge where in_valid and
// in_ready are both high. in_valid must not depend on in_ready. in_ready is
// high only in LOAD while count < DEPTH. start on the same edge wins over a
// transfer, and that descriptor is dropped.
//
// BASE_ADDR must be a multiple of 4.
// -----------------------------------------------------------------------------
module mips_inst_encoder #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 DEPTH     = 1024,
    localparam int                CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              full,
    output logic [CW-1:0]     count
);

    // Symbolic op codes presented on in_op.
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd4;
    localparam logic [4:0] OP_SLTU = 5'd5;
    localparam logic [4:0] OP_ADDU = 5'd6;
    localparam logic [4:0] OP_SUBU = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8;
    localparam logic [4:0] OP_SRL  = 5'd9;
    localparam logic [4:0] OP_SRA  = 5'd10;
    localparam logic [4:0] OP_SLLV = 5'd11;
    localparam logic [4:0] OP_SRLV = 5'd12;
    localparam logic [4:0] OP_SRAV = 5'd13;
    localparam logic [4:0] OP_XOR  = 5'd14;
    localparam logic [4:0] OP_NOR  = 5'd15;
    localparam logic [4:0] OP_JR   = 5'd16;
    localparam logic [4:0] OP_JALR = 5'd17;
    localparam logic [4:0] OP_ADDI = 5'd18;
    localparam logic [4:0] OP_ORI  = 5'd19;
    localparam logic [4:0] OP_LW   = 5'd20;
    localparam logic [4:0] OP_SW   = 5'd21;
    localparam logic [4:0] OP_BEQ  = 5'd22;
    localparam logic [4:0] OP_BNE  = 5'd23;
    localparam logic [4:0] OP_J    = 5'd24;
    localparam logic [4:0] OP_JAL  = 5'd25;

    // MIPS primary opcodes (the same values the CPU control decoder uses).
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type funct codes.
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_inc;
    logic              accept;
    logic              fills;
    logic [31:0]       enc_word;
    logic              enc_legal;

    // ------------------------------------------------------------------
    // Combinational encoder: every field not used by the format is forced
    // to zero so stray descriptor bits never leak into the word.
    // ------------------------------------------------------------------
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (in_op)
            OP_ADD:  enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_ADD};
            OP_SUB:  enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SUB};
            OP_AND:  enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_AND};
            OP_OR:   enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_OR};
            OP_SLT:  enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SLT};
            OP_SLTU: enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SLTU};
            OP_ADDU: enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_ADDU};
            OP_SUBU: enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SUBU};
            OP_XOR:  enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_XOR};
            OP_NOR:  enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_NOR};
            // Constant shifts take the amount from shamt; rs is unused.
            OP_SLL:  enc_word = {OPC_RTYPE, 5'b0, in_rt, in_rd, in_shamt, FN_SLL};
            OP_SRL:  enc_word = {OPC_RTYPE, 5'b0, in_rt, in_rd, in_shamt, FN_SRL};
            OP_SRA:  enc_word = {OPC_RTYPE, 5'b0, in_rt, in_rd, in_shamt, FN_SRA};
            // Variable shifts take the amount from rs; shamt is unused.
            OP_SLLV: enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SLLV};
            OP_SRLV: enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SRLV};
            OP_SRAV: enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SRAV};
            OP_JR:   enc_word = {OPC_RTYPE, in_rs, 15'b0, FN_JR};
            OP_JALR: enc_word = {OPC_RTYPE, in_rs, 5'b0, in_rd, 5'b0, FN_JALR};
            OP_ADDI: enc_word = {OPC_ADDI, in_rs, in_rt, in_imm[15:0]};
            OP_ORI:  enc_word = {OPC_ORI,  in_rs, in_rt, in_imm[15:0]};
            OP_LW:   enc_word = {OPC_LW,   in_rs, in_rt, in_imm[15:0]};
            OP_SW:   enc_word = {OPC_SW,   in_rs, in_rt, in_imm[15:0]};
            OP_BEQ:  enc_word = {OPC_BEQ,  in_rs, in_rt, in_imm[15:0]};
            OP_BNE:  enc_word = {OPC_BNE,  in_rs, in_rt, in_imm[15:0]};
            OP_J:    enc_word = {OPC_J,   in_imm};
            OP_JAL:  enc_word = {OPC_JAL, in_imm};
            default: enc_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and session bookkeeping
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == LOAD) && (count_q < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign count_inc = count_q + 1'b1;
    // This legal accept writes the last word the session can hold.
    assign fills     = enc_legal && (count_inc == CW'(DEPTH));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = LOAD;
        end else if ((state_q == LOAD) && accept) begin
            if (in_last || fills) begin
                state_d = DONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: the word is captured on the accepting edge and presented
    // on the IM port for exactly the following cycle. Address and count
    // advance on that same edge so back-to-back accepts land at
    // consecutive addresses with no gaps.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            im_we       <= 1'b0;
            im_addr     <= BASE_ADDR;
            im_wdata    <= 32'h0;
            next_addr_q <= BASE_ADDR;
            count_q     <= '0;
            err         <= 1'b0;
            full        <= 1'b0;
        end else begin
            im_we <= 1'b0;
            if (start) begin
                next_addr_q <= BASE_ADDR;
                count_q     <= '0;
                err         <= 1'b0;
                full        <= 1'b0;
            end else if (accept) begin
                if (enc_legal) begin
                    im_we       <= 1'b1;
                    im_addr     <= next_addr_q;
                    im_wdata    <= enc_word;
                    next_addr_q <= next_addr_q + ADDR_W'(4);
                    count_q     <= count_inc;
                    // in_last on the filling word is a clean finish, not overflow.
                    if (fills && !in_last) begin
                        full <= 1'b1;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign count = count_q;
    assign busy  = (state_q == LOAD);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_mips_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_mips_inst_encoder
//
// Drives descriptor sessions into mips_inst_encoder (DEPTH=4 so the overflow
// path is reachable) and checks every IM write against an expected queue of
// {address, word} pairs. Session status (done/count/err/full/in_ready) is
// checked inline by each scenario task.
// -----------------------------------------------------------------------------
module tb_mips_inst_encoder;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk;
    logic              rstn;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [25:0]       in_imm;
    logic              in_last;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              full;
    logic [CW-1:0]     count;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W-1:0]  exp_addr;

    mips_inst_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR ('0),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .in_rd    (in_rd),
        .in_shamt (in_shamt),
        .in_imm   (in_imm),
        .in_last  (in_last),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .full     (full),
        .count    (count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard: IM writes ----------------
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%08h data=%08h", im_addr, im_wdata);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                if ({im_addr, im_wdata} !== e) begin
                    bad++;
                    $display("FAIL im_write got addr=%08h data=%08h want addr=%08h data=%08h",
                             im_addr, im_wdata, e[ADDR_W+31:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- reference encoder ----------------
    function automatic logic [31:0] ref_encode(input logic [4:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [4:0] sh, input logic [25:0] imm);
        logic [5:0] fn;
        logic [5:0] opc;
        case (op)
            5'd0: fn = 6'h20;  5'd1: fn = 6'h22;  5'd2: fn = 6'h24;  5'd3: fn = 6'h25;
            5'd4: fn = 6'h2A;  5'd5: fn = 6'h2B;  5'd6: fn = 6'h21;  5'd7: fn = 6'h23;
            5'd8: fn = 6'h00;  5'd9: fn = 6'h02;  5'd10: fn = 6'h03; 5'd11: fn = 6'h04;
            5'd12: fn = 6'h06; 5'd13: fn = 6'h07; 5'd14: fn = 6'h26; 5'd15: fn = 6'h27;
            5'd16: fn = 6'h08; 5'd17: fn = 6'h09;
            default: fn = 6'h00;
        endcase
        case (op)
            5'd18: opc = 6'h08; 5'd19: opc = 6'h0D; 5'd20: opc = 6'h23; 5'd21: opc = 6'h2B;
            5'd22: opc = 6'h04; 5'd23: opc = 6'h05; 5'd24: opc = 6'h02; 5'd25: opc = 6'h03;
            default: opc = 6'h00;
        endcase
        if (op <= 5'd7 || op == 5'd14 || op == 5'd15 || (op >= 5'd11 && op <= 5'd13))
            return {6'h00, rs, rt, rd, 5'd0, fn};
        else if (op >= 5'd8 && op <= 5'd10)
            return {6'h00, 5'd0, rt, rd, sh, fn};
        else if (op == 5'd16)
            return {6'h00, rs, 15'd0, fn};
        else if (op == 5'd17)
            return {6'h00, rs, 5'd0, rd, 5'd0, fn};
        else if (op >= 5'd18 && op <= 5'd23)
            return {opc, rs, rt, imm[15:0]};
        else
            return {opc, imm};
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_start();
        start = 1'b1;
        exp_addr = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents a descriptor (leaves in_valid high) and waits for it to be taken.
    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm,
                        input logic last, input logic [31:0] expw);
        logic got;
        logic rdy;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_last = last; in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_timeout op=%0d got=not_accepted want=accepted", op);
        end else if (op < 5'd26) begin
            exp_q.push_back({exp_addr, expw});
            exp_addr = exp_addr + 4;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d_pending want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        total++;
        if ({im_we, im_addr, im_wdata, err, full, count, in_ready, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_state got we=%b addr=%08h data=%08h err=%b full=%b cnt=%0d rdy=%b busy=%b done=%b want all 0",
                     im_we, im_addr, im_wdata, err, full, count, in_ready, busy, done);
        end
    endtask

    task automatic test_basic();
        do_start();
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || count !== '0) begin
            bad++;
            $display("FAIL start_load got busy=%b rdy=%b cnt=%0d want 1 1 0", busy, in_ready, count);
        end
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0, 32'h00221820);
        send(5'd18, 5'd1, 5'd2, 5'd0, 5'd0, 26'd5, 1'b1, 32'h20220005);
        total++;
        if (in_ready !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL last_drop_ready got rdy=%b done=%b want 0 1", in_ready, done);
        end
        idle();
        wait_drain();
        total++;
        if (done !== 1'b1 || count !== 3'd2 || err !== 1'b0 || full !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_status got done=%b cnt=%0d err=%b full=%b busy=%b want 1 2 0 0 0",
                     done, count, err, full, busy);
        end
    endtask

    task automatic test_fields();
        do_start();
        send(5'd8, 5'd7, 5'd2, 5'd4, 5'd3, 26'h3FFFFFF, 1'b0, 32'h000220C0);
        send(5'd16, 5'd31, 5'd5, 5'd6, 5'd7, 26'h3FFFFFF, 1'b1, 32'h03E00008);
        idle();
        wait_drain();
    endtask

    task automatic test_jump_branch();
        do_start();
        send(5'd25, 5'd9, 5'd9, 5'd9, 5'd9, 26'h000C00, 1'b0, 32'h0C000C00);
        send(5'd22, 5'd1, 5'd2, 5'd9, 5'd9, {10'h3FF, 16'hFFFF}, 1'b1, 32'h1022FFFF);
        idle();
        wait_drain();
    endtask

    task automatic test_illegal();
        do_start();
        send(5'd0, 5'd4, 5'd5, 5'd6, 5'd0, 26'd0, 1'b0, 32'h00853020);
        send(5'd27, 5'd1, 5'd1, 5'd1, 5'd1, 26'd1, 1'b0, 32'h0);
        total++;
        if (err !== 1'b1 || count !== 3'd1) begin
            bad++;
            $display("FAIL illegal_sticky got err=%b cnt=%0d want 1 1", err, count);
        end
        send(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 26'd0, 1'b1, 32'h00853022);
        idle();
        wait_drain();
        total++;
        if (err !== 1'b1 || count !== 3'd2 || done !== 1'b1 || im_addr !== 32'h4) begin
            bad++;
            $display("FAIL illegal_session got err=%b cnt=%0d done=%b addr=%08h want 1 2 1 00000004",
                     err, count, done, im_addr);
        end
        // An illegal descriptor carrying in_last still closes the session.
        do_start();
        send(5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 32'h0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || err !== 1'b1 || count !== '0) begin
            bad++;
            $display("FAIL illegal_last got done=%b err=%b cnt=%0d want 1 1 0", done, err, count);
        end
    endtask

    task automatic test_full();
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            logic [4:0] rs;
            logic [4:0] rt;
            logic [4:0] rd;
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            send(5'd6, rs, rt, rd, 5'd0, 26'd0, 1'b0, ref_encode(5'd6, rs, rt, rd, 5'd0, 26'd0));
        end
        total++;
        if (full !== 1'b1 || in_ready !== 1'b0 || done !== 1'b1 || count !== 3'd4) begin
            bad++;
            $display("FAIL full_hit got full=%b rdy=%b done=%b cnt=%0d want 1 0 1 4",
                     full, in_ready, done, count);
        end
        // Fifth descriptor stays valid but must never be consumed.
        in_op = 5'd3; in_rs = 5'd1; in_rt = 5'd1; in_rd = 5'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL full_no_ready got rdy=%b want 0", in_ready);
            end
        end
        @(posedge clk); #1;
        idle();
        wait_drain();
        total++;
        if (count !== 3'd4 || full !== 1'b1) begin
            bad++;
            $display("FAIL full_hold got cnt=%0d full=%b want 4 1", count, full);
        end
    endtask

    task automatic test_start_priority();
        do_start();
        send(5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0, 1'b0, 32'h00210820);
        // start and a valid descriptor on the same edge: descriptor is dropped.
        in_op = 5'd1; in_rs = 5'd2; in_rt = 5'd2; in_rd = 5'd2; in_valid = 1'b1;
        start = 1'b1;
        exp_addr = '0;
        @(posedge clk); #1;
        start = 1'b0;
        idle();
        total++;
        if (count !== '0 || busy !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL start_priority got cnt=%0d busy=%b err=%b want 0 1 0", count, busy, err);
        end
        send(5'd3, 5'd3, 5'd4, 5'd5, 5'd0, 26'd0, 1'b1, 32'h00642825);
        idle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 4; s++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            do_start();
            for (int i = 0; i < n; i++) begin
                logic [4:0]  op;
                logic [4:0]  rs;
                logic [4:0]  rt;
                logic [4:0]  rd;
                logic [4:0]  sh;
                logic [25:0] imm;
                op  = 5'($urandom_range(0, 25));
                rs  = 5'($urandom_range(0, 31));
                rt  = 5'($urandom_range(0, 31));
                rd  = 5'($urandom_range(0, 31));
                sh  = 5'($urandom_range(0, 31));
                imm = 26'($urandom);
                send(op, rs, rt, rd, sh, imm, (i == n - 1), ref_encode(op, rs, rt, rd, sh, imm));
            end
            idle();
            wait_drain();
            total++;
            if (count !== CW'(n) || done !== 1'b1 || full !== 1'b0) begin
                bad++;
                $display("FAIL b2b_status got cnt=%0d done=%b full=%b want %0d 1 0", count, done, full, n);
            end
        end
    endtask

    task automatic test_reset_abort();
        do_start();
        send(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0, 32'h00221824);
        send(5'd2, 5'd4, 5'd5, 5'd6, 5'd0, 26'd0, 1'b0, 32'h00853024);
        // The second write is on the port now; reset must kill it.
        void'(exp_q.pop_back());
        rstn = 1'b0;
        #1;
        total++;
        if ({im_we, im_addr, im_wdata, err, full, count, in_ready, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_abort got we=%b addr=%08h data=%08h err=%b full=%b cnt=%0d rdy=%b busy=%b done=%b want all 0",
                     im_we, im_addr, im_wdata, err, full, count, in_ready, busy, done);
        end
        idle();
        @(negedge clk);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        do_start();
        send(5'd19, 5'd1, 5'd2, 5'd0, 5'd0, 26'h00ABCD, 1'b1, 32'h3422ABCD);
        idle();
        wait_drain();
        // Restart from DONE: count clears and writes begin at BASE_ADDR again.
        do_start();
        total++;
        if (count !== '0 || busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL restart_done got cnt=%0d busy=%b done=%b want 0 1 0", count, busy, done);
        end
        send(5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 26'h1234567, 1'b1, 32'h09234567);
        idle();
        wait_drain();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0;
        in_rd = '0; in_shamt = '0; in_imm = '0; in_last = 1'b0; exp_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_fields();
        test_jump_branch();
        test_illegal();
        test_full();
        test_start_priority();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_inst_encoder.md
Name: mips_inst_encoder

Overview:
- Inverse of the CPU's instruction decoder: takes symbolic instruction descriptors over a valid/ready stream, encodes them into 32-bit MIPS words, and writes them sequentially into instruction memory.
- Used by the test/boot loader path to fill IM before the CPU is released.
- Covers exactly the instruction set the CPU decodes.
- Opcode/funct values come from the shared control encoding definitions header.

Parameters:
ADDR_W, 32, width of im_addr (byte address)
BASE_ADDR, 0, byte address of first written word; must be 4-aligned
DEPTH, 1024, max words per load session; count width CW = clog2(DEPTH+1)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse: begin/restart a load session
in_valid  in  1  descriptor valid
in_ready  out  1  encoder can accept a descriptor
in_op  in  5  0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 SLTU,6 ADDU,7 SUBU,8 SLL,9 SRL,10 SRA,11 SLLV,12 SRLV,13 SRAV,14 XOR,15 NOR,16 JR,17 JALR,18 ADDI,19 ORI,20 LW,21 SW,22 BEQ,23 BNE,24 J,25 JAL; 26-31 illegal
in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
in_imm  in  26  imm26 for J/JAL; [15:0] = imm16 for I-type
in_last  in  1  descriptor is final of session
im_we  out  1  IM write strobe
im_addr  out  ADDR_W  IM byte address
im_wdata  out  32  encoded instruction
busy  out  1  state == LOAD
done  out  1  state == DONE
err  out  1  sticky: illegal op seen this session
full  out  1  sticky: DEPTH reached without in_last
count  out  CW  words written this session

Behaviour:
- Reset (rstn low, async): state IDLE; im_we=0, im_addr=BASE_ADDR, im_wdata=0, err=0, full=0, count=0, in_ready=0. Deassertion is synchronous to clk.
- FSM states IDLE, LOAD, DONE.
  - start in any state -> LOAD: next_addr=BASE_ADDR, count=0, err=0, full=0.
  - start has priority over a handshake in the same cycle; that descriptor is dropped.
- in_ready = (state==LOAD) && (count < DEPTH). Accept = in_valid && in_ready.
- Encoding (combinational from inputs, registered on accept); unused fields are forced to 0:
  - R-ALU ops 0-7, 14, 15: {0, rs, rt, rd, 5'b0, funct}.
  - SLL/SRL/SRA: {0, 5'b0, rt, rd, shamt, funct}.
  - SLLV/SRLV/SRAV: {0, rs, rt, rd, 5'b0, funct}.
  - JR: {0, rs, 15'b0, 0x08}.
  - JALR: {0, rs, 5'b0, rd, 5'b0, 0x09}.
  - ADDI/ORI/LW/SW/BEQ/BNE: {opcode, rs, rt, imm[15:0]}.
  - J/JAL: {opcode, imm[25:0]}.
- Write latency is 1 cycle. The cycle after a legal accept: im_we=1 for exactly one cycle, im_addr=next_addr, im_wdata=encoded word. next_addr += 4 (wraps mod 2^ADDR_W) and count += 1 on the same edge.
- Back-to-back accepts produce back-to-back writes at consecutive addresses. No stall path exists.
- Illegal op accepted: no write, no address/count change, err set; in_last still honoured.
- in_last accepted: LOAD -> DONE on the same edge; the final write (if legal) still issues the next cycle. in_ready drops immediately.
- The accept that makes count reach DEPTH without in_last: full=1, -> DONE.
- DONE holds done=1 and count/err/full stable until start. IDLE and DONE ignore in_valid.
- rstn asserted mid-session aborts immediately; a pending write is lost and im_we goes 0 asynchronously.

Test Plan:
1. Reset, start, stream ADD rs1 rt2 rd3 then ADDI rs1 rt2 imm5 (last) -> writes 0x00221820 @0x0, 0x20220005 @0x4; done=1, count=2, err=0.
2. SLL rt2 rd4 shamt3 with in_rs=7; JR rs31 with rt/rd/shamt nonzero -> 0x000220C0, 0x03E00008 (stray fields zeroed).
3. JAL imm26=0x000C00; BEQ rs1 rt2 imm16=0xFFFF with in_imm[25:16]=0x3FF -> 0x0C000C00, 0x1022FFFF.
4. in_op=27 between two legal ops -> err=1, only 2 writes at 0x0/0x4, count=2; in_op=27 with in_last -> DONE.
5. DEPTH=4, 5 descriptors, in_valid held high, no last -> 4 writes, full=1, in_ready=0 after the 4th accept, 5th not consumed.
6. rstn low during LOAD after 2 accepts -> outputs at reset values. Then start during DONE -> count=0, address restarts at BASE_ADDR.
